// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: frame geometry, receiver
// states and the default bit period for the 48 MHz core clock.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 417;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Core-side bundle of the UART receiver: byte holding register handshake plus
// framing/overrun status. The receiver is the master, the consumer the slave.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ready,
    input  clr_overrun
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ready,
    output clr_overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs. The reset value is a
// parameter so idle-high pins do not look active while reset is held.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_core,
  input  logic core_reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples the synchronized RX line at bit midpoints and
// delivers bytes through a single-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      clk_core,
  input  logic      core_reset_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 deliver;
  logic                 stop_bad;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 overrun_q;
  logic                 frame_err_q;

  // Preset to 1 so the idle-high line is not mistaken for a start bit after reset.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .d            (rx),
    .q            (rx_s)
  );

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    deliver     = 1'b0;
    stop_bad    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      // Half a bit period in, a line that is high again was only a glitch.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // Returning to IDLE right at the stop sample keeps an early next start edge.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // A consumer taking the old byte on the delivery edge frees the slot in time.
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;

      if (deliver) begin
        if (!valid_q || bus.rx_ready) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end

      if (deliver && valid_q && !bus.rx_ready) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit: delivery
// timing, glitch reject, framing/break, overrun, back-to-back handoff, reset.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLKS = 16;
  // Start edge to delivery: 2 sync + 1 IDLE + 8 half bit + 8 data + 1 stop bit periods.
  localparam int DELIVERY_LAT = 155;

  logic clk_core     = 1'b0;
  logic core_reset_n = 1'b0;
  logic rx           = 1'b1;

  int checks   = 0;
  int failures = 0;

  int cyc            = 0;
  int start_cyc      = 0;
  int valid_rises    = 0;
  int valid_high     = 0;
  int ferr_high      = 0;
  int last_rise_cyc  = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_valid   = 1'b0;

  int snap_rises;
  int snap_high;
  int snap_ferr;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .rx           (rx),
    .bus          (bus)
  );

  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) cyc <= cyc + 1;

  always @(negedge clk_core) begin
    if (bus.rx_valid && !prev_valid) begin
      valid_rises   = valid_rises + 1;
      last_rise_cyc = cyc;
      last_data     = bus.rx_data;
    end
    if (bus.rx_valid)  valid_high = valid_high + 1;
    if (bus.frame_err) ferr_high  = ferr_high + 1;
    prev_valid = bus.rx_valid;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends start, 8 data bits LSB first and the given stop level; rx is left at that level.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    @(posedge clk_core); #1;
    rx        = 1'b0;
    start_cyc = cyc;
    repeat (CLKS) @(posedge clk_core); #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(posedge clk_core); #1;
    end
    rx = stop_bit;
    repeat (CLKS) @(posedge clk_core); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_data"},  32'(bus.rx_data),   32'h00);
    check_output({tag, "_valid"}, 32'(bus.rx_valid),  32'h0);
    check_output({tag, "_ferr"},  32'(bus.frame_err), 32'h0);
    check_output({tag, "_ovr"},   32'(bus.overrun),   32'h0);
    check_output({tag, "_busy"},  32'(bus.busy),      32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.rx_ready    = 1'b0;
    bus.clr_overrun = 1'b0;

    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    check_reset_outputs("reset");
    #1 core_reset_n = 1'b1;
    repeat (5) @(posedge clk_core);

    $display("[TB] basic frame 0xA5 with rx_ready=1");
    bus.rx_ready = 1'b1;
    snap_rises = valid_rises; snap_high = valid_high; snap_ferr = ferr_high;
    apply_stimulus(8'hA5, 1'b1);
    @(negedge clk_core);
    check_output("a5_rises",   32'(valid_rises - snap_rises), 32'd1);
    check_output("a5_latency", 32'(last_rise_cyc - start_cyc), 32'(DELIVERY_LAT));
    check_output("a5_data",    32'(last_data), 32'hA5);
    check_output("a5_vcycles", 32'(valid_high - snap_high), 32'd1);
    check_output("a5_ferr",    32'(ferr_high - snap_ferr), 32'd0);
    check_output("a5_ovr",     32'(bus.overrun), 32'h0);

    $display("[TB] glitch reject");
    repeat (10) @(posedge clk_core);
    snap_rises = valid_rises; snap_ferr = ferr_high;
    @(posedge clk_core); #1 rx = 1'b0;
    repeat (5) @(posedge clk_core);
    @(negedge clk_core);
    check_output("glitch_busy_mid", 32'(bus.busy), 32'h1);
    rx = 1'b1;
    repeat (40) @(posedge clk_core);
    @(negedge clk_core);
    check_output("glitch_busy_end", 32'(bus.busy), 32'h0);
    check_output("glitch_rises",    32'(valid_rises - snap_rises), 32'd0);
    check_output("glitch_ferr",     32'(ferr_high - snap_ferr), 32'd0);

    $display("[TB] framing error and held break");
    snap_rises = valid_rises; snap_ferr = ferr_high;
    apply_stimulus(8'h3C, 1'b0);
    repeat (100 * CLKS) @(posedge clk_core);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk_core);
    @(negedge clk_core);
    check_output("break_ferr",  32'(ferr_high - snap_ferr), 32'd1);
    check_output("break_rises", 32'(valid_rises - snap_rises), 32'd0);
    apply_stimulus(8'h81, 1'b1);
    @(negedge clk_core);
    check_output("after_break_rises", 32'(valid_rises - snap_rises), 32'd1);
    check_output("after_break_data",  32'(last_data), 32'h81);

    $display("[TB] overrun with rx_ready=0");
    bus.rx_ready = 1'b0;
    repeat (10) @(posedge clk_core);
    apply_stimulus(8'h11, 1'b1);
    apply_stimulus(8'h22, 1'b1);
    @(negedge clk_core);
    check_output("ovr_data",  32'(bus.rx_data),  32'h11);
    check_output("ovr_valid", 32'(bus.rx_valid), 32'h1);
    check_output("ovr_flag",  32'(bus.overrun),  32'h1);
    @(posedge clk_core); #1 bus.clr_overrun = 1'b1;
    @(posedge clk_core); #1 bus.clr_overrun = 1'b0;
    @(negedge clk_core);
    check_output("ovr_cleared", 32'(bus.overrun), 32'h0);
    @(posedge clk_core); #1 bus.rx_ready = 1'b1;
    @(posedge clk_core); #1 bus.rx_ready = 1'b0;
    @(negedge clk_core);
    check_output("consume_valid", 32'(bus.rx_valid), 32'h0);
    check_output("consume_hold",  32'(bus.rx_data),  32'h11);

    $display("[TB] consume and deliver on the same edge");
    apply_stimulus(8'h11, 1'b1);
    snap_rises = valid_rises;
    fork
      apply_stimulus(8'h22, 1'b1);
      begin
        repeat (DELIVERY_LAT) @(posedge clk_core);
        #1 bus.rx_ready = 1'b1;
        @(posedge clk_core);
        #1 bus.rx_ready = 1'b0;
      end
    join
    @(negedge clk_core);
    check_output("handoff_data",  32'(bus.rx_data),  32'h22);
    check_output("handoff_valid", 32'(bus.rx_valid), 32'h1);
    check_output("handoff_ovr",   32'(bus.overrun),  32'h0);
    check_output("handoff_rises", 32'(valid_rises - snap_rises), 32'd0);

    $display("[TB] reset during bit 4 of 0xFF");
    snap_rises = valid_rises;
    fork
      apply_stimulus(8'hFF, 1'b1);
      begin
        repeat (5 * CLKS + 8) @(posedge clk_core);
        #1 core_reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(posedge clk_core);
        #1 core_reset_n = 1'b1;
      end
    join
    repeat (40) @(posedge clk_core);
    @(negedge clk_core);
    check_output("ff_not_delivered", 32'(valid_rises - snap_rises), 32'd0);
    bus.rx_ready = 1'b1;
    apply_stimulus(8'h5A, 1'b1);
    @(negedge clk_core);
    check_output("post_reset_rises", 32'(valid_rises - snap_rises), 32'd1);
    check_output("post_reset_data",  32'(last_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
